// File: rtl/sort4_ctrl_pkg.sv
// sort4_ctrl shared types: FSM encoding, sizes,
// and the pass-end helper for the bubble schedule.
package sort4_ctrl_pkg;

  localparam int NUM_ELEM  = 4;
  localparam int ELEM_W    = 4;
  localparam int LAST_PASS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [ELEM_W-1:0] elem_t;

  // last compare index of a pass shrinks by one
  // each pass as the tail becomes final
  function automatic logic [1:0] pass_end(
    input logic [1:0] pass
  );
    return 2'(LAST_PASS) - pass;
  endfunction

endpackage

// File: rtl/sort4_ctrl_if.sv
// Producer/consumer valid-ready bundle for sort4_ctrl.
// slave = sorter side, master = producer/consumer side.
interface sort4_ctrl_if;
  import sort4_ctrl_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  swap_count;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output swap_count
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  swap_count
  );

endinterface

// File: rtl/sort4_ctrl_cmp.sv
// fourbit_comparator: unsigned 4-bit magnitude compare.
// Ports: a, b operands; gt/eq/lt one-hot result.
module fourbit_comparator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  assign gt = a > b;
  assign eq = a == b;
  assign lt = a < b;

endmodule

// File: rtl/sort4_ctrl.sv
// sort4_ctrl: bubble-sorts four 4-bit values, one compare/clk.
// Ports: clk, rst_n, io (valid/ready in+out, swap_count), busy.
module sort4_ctrl
  import sort4_ctrl_pkg::*;
#(
  parameter bit DESCENDING = 1'b0,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  sort4_ctrl_if.slave  io,
  output logic         busy
);

  state_t      state_q;
  state_t      state_d;
  elem_t       r [NUM_ELEM];
  logic [1:0]  pass_q;
  logic [1:0]  idx_q;
  logic [2:0]  sc_q;
  logic        swp_q;

  elem_t       op_a;
  elem_t       op_b;
  logic        gt;
  logic        eq;
  logic        lt;
  logic        do_swap;
  logic        last;
  logic        fin;
  logic [1:0]  idx_n;

  assign idx_n = idx_q + 2'd1;

  always_comb begin
    op_a = r[idx_q];
    op_b = r[idx_n];
  end

  fourbit_comparator u_cmp (
    .a  (op_a),
    .b  (op_b),
    .gt (gt),
    .eq (eq),
    .lt (lt)
  );

  // equal operands never swap, keeping the sort stable
  assign do_swap = DESCENDING ? (lt & ~eq)
                              : (gt & ~eq);

  assign last = idx_q == pass_end(pass_q);

  // early exit looks at the current step too
  assign fin = last &&
    (pass_q == 2'(LAST_PASS) ||
     (EARLY_EXIT && !(swp_q || do_swap)));

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE):
        if (io.in_valid) state_d = CMP;
      (state_q == CMP):
        if (fin) state_d = DONE;
      (state_q == DONE):
        if (io.out_ready) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pass_q  <= '0;
      idx_q   <= '0;
      sc_q    <= '0;
      swp_q   <= 1'b0;
      for (int k = 0; k < NUM_ELEM; k++)
        r[k] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && io.in_valid) begin
        pass_q <= '0;
        idx_q  <= '0;
        sc_q   <= '0;
        swp_q  <= 1'b0;
        for (int k = 0; k < NUM_ELEM; k++)
          r[k] <= io.in_data[k*ELEM_W +: ELEM_W];
      end else if (state_q == CMP) begin
        if (do_swap) begin
          r[idx_q] <= op_b;
          r[idx_n] <= op_a;
          sc_q     <= sc_q + 3'd1;
          swp_q    <= 1'b1;
        end
        if (last) begin
          pass_q <= pass_q + 2'd1;
          idx_q  <= '0;
          swp_q  <= 1'b0;
        end else begin
          idx_q  <= idx_n;
        end
      end
    end
  end

  assign io.in_ready   = state_q == IDLE;
  assign io.out_valid  = state_q == DONE;
  assign io.out_data   = {r[3], r[2], r[1], r[0]};
  assign io.swap_count = sc_q;
  assign busy          = state_q == CMP;

endmodule

// File: tb/tb_sort4_ctrl.sv
// Bench for sort4_ctrl: three configs (asc/early,
// asc/full, desc/early), vector table + scoreboard.
module tb_sort4_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [15:0] idat [3];
  logic [2:0]  irdy;
  logic [2:0]  ov;
  logic [2:0]  bsy;
  logic [15:0] odat [3];
  logic [2:0]  sc   [3];

  int checks;
  int failures;

  sort4_ctrl_if if0 ();
  sort4_ctrl_if if1 ();
  sort4_ctrl_if if2 ();

  assign if0.in_valid  = iv[0];
  assign if0.in_data   = idat[0];
  assign if0.out_ready = ordy[0];
  assign irdy[0]       = if0.in_ready;
  assign ov[0]         = if0.out_valid;
  assign odat[0]       = if0.out_data;
  assign sc[0]         = if0.swap_count;

  assign if1.in_valid  = iv[1];
  assign if1.in_data   = idat[1];
  assign if1.out_ready = ordy[1];
  assign irdy[1]       = if1.in_ready;
  assign ov[1]         = if1.out_valid;
  assign odat[1]       = if1.out_data;
  assign sc[1]         = if1.swap_count;

  assign if2.in_valid  = iv[2];
  assign if2.in_data   = idat[2];
  assign if2.out_ready = ordy[2];
  assign irdy[2]       = if2.in_ready;
  assign ov[2]         = if2.out_valid;
  assign odat[2]       = if2.out_data;
  assign sc[2]         = if2.swap_count;

  sort4_ctrl #(.DESCENDING(1'b0), .EARLY_EXIT(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .io(if0), .busy(bsy[0])
  );
  sort4_ctrl #(.DESCENDING(1'b0), .EARLY_EXIT(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .io(if1), .busy(bsy[1])
  );
  sort4_ctrl #(.DESCENDING(1'b1), .EARLY_EXIT(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .io(if2), .busy(bsy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  sc;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  typedef struct {
    logic [15:0] din;
    logic [15:0] asc_d;
    logic [2:0]  asc_sc;
    int          lat_e;
    int          lat_f;
    logic [15:0] dsc_d;
    logic [2:0]  dsc_sc;
    int          dsc_lat;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [15:0] pk(
    input int e0, input int e1,
    input int e2, input int e3
  );
    return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
  endfunction

  task automatic chk(
    input string nm, input int act, input int exp
  );
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d",
               nm, act, exp);
    end
  endtask

  task automatic push_exp(
    input int d, input logic [15:0] ed,
    input logic [2:0] es
  );
    exp_t e;
    e.d  = ed;
    e.sc = es;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_check(input int d);
    exp_t e;
    bit   ok;
    ok = 1'b1;
    e  = '0;
    case (d)
      0: if (q0.size() > 0) e = q0.pop_front();
         else ok = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front();
         else ok = 1'b0;
      default:
         if (q2.size() > 0) e = q2.pop_front();
         else ok = 1'b0;
    endcase
    if (!ok) begin
      chk($sformatf("sb_unexpected_out%0d", d), 1, 0);
    end else begin
      chk($sformatf("out_data%0d", d),
          int'(odat[d]), int'(e.d));
      chk($sformatf("swap_count%0d", d),
          int'(sc[d]), int'(e.sc));
    end
  endtask

  // handshake is sampled mid-cycle, ahead of its edge
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++)
        if (ov[d] && ordy[d]) sb_check(d);
    end
  end

  task automatic run_vec(
    input int d, input logic [15:0] din,
    input logic [15:0] ed, input logic [2:0] es,
    input int lat
  );
    int n;
    bit seen;
    @(negedge clk);
    n = 0;
    while (!irdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("in_ready%0d", d), int'(irdy[d]), 1);
    idat[d] = din;
    iv[d]   = 1'b1;
    @(posedge clk);
    push_exp(d, ed, es);
    #1;
    iv[d] = 1'b0;
    chk($sformatf("busy%0d", d), int'(bsy[d]), 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (ov[d]) seen = 1'b1;
    end
    chk($sformatf("latency%0d", d), n, lat);
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    chk($sformatf("post_hs_valid%0d", d),
        int'(ov[d]), 0);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    iv       = '0;
    ordy     = '0;
    for (int d = 0; d < 3; d++) idat[d] = '0;

    tbl[0] = '{pk(9,3,7,1),  pk(1,3,7,9),  3'd5, 6, 6,
               pk(9,7,3,1),  3'd1, 5};
    tbl[1] = '{pk(1,2,3,4),  pk(1,2,3,4),  3'd0, 3, 6,
               pk(4,3,2,1),  3'd6, 6};
    tbl[2] = '{pk(0,15,8,8), pk(0,8,8,15), 3'd2, 5, 6,
               pk(15,8,8,0), 3'd3, 5};
    tbl[3] = '{pk(15,10,5,0), pk(0,5,10,15), 3'd6, 6, 6,
               pk(15,10,5,0), 3'd0, 3};
    tbl[4] = '{pk(4,4,4,4),  pk(4,4,4,4),  3'd0, 3, 6,
               pk(4,4,4,4),  3'd0, 3};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_in_ready%0d", d),
          int'(irdy[d]), 1);
      chk($sformatf("rst_out_valid%0d", d),
          int'(ov[d]), 0);
      chk($sformatf("rst_swap%0d", d), int'(sc[d]), 0);
      chk($sformatf("rst_busy%0d", d), int'(bsy[d]), 0);
      chk($sformatf("rst_data%0d", d), int'(odat[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_vec(0, tbl[i].din, tbl[i].asc_d,
              tbl[i].asc_sc, tbl[i].lat_e);
      run_vec(1, tbl[i].din, tbl[i].asc_d,
              tbl[i].asc_sc, tbl[i].lat_f);
      run_vec(2, tbl[i].din, tbl[i].dsc_d,
              tbl[i].dsc_sc, tbl[i].dsc_lat);
    end

    // backpressure: stall 10 cycles with a stray in_valid
    @(negedge clk);
    idat[0] = pk(9,3,7,1);
    iv[0]   = 1'b1;
    @(posedge clk);
    push_exp(0, pk(1,3,7,9), 3'd5);
    #1;
    idat[0] = pk(2,2,2,2);
    n = 0;
    while (!ov[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_latency", n, 6);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", int'(ov[0]), 1);
      chk("bp_data", int'(odat[0]),
          int'(pk(1,3,7,9)));
      chk("bp_swap", int'(sc[0]), 5);
      chk("bp_in_ready", int'(irdy[0]), 0);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    chk("bp_idle", int'(irdy[0]), 1);
    run_vec(0, pk(15,10,5,0), pk(0,5,10,15),
            3'd6, 6);

    // reset during the second compare cycle
    @(negedge clk);
    idat[0] = pk(15,10,5,0);
    iv[0]   = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy", int'(bsy[0]), 1);
    chk("mid_swap_pre", int'(sc[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", int'(ov[0]), 0);
    chk("mid_swap", int'(sc[0]), 0);
    chk("mid_in_ready", int'(irdy[0]), 1);
    chk("mid_busy_rst", int'(bsy[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0, pk(4,4,4,4), pk(4,4,4,4), 3'd0, 3);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty",
        q0.size() + q1.size() + q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/sort4_ctrl.md
Name: sort4_ctrl

Overview:
- Sequencer that sorts four 4-bit values using one shared 4-bit magnitude comparator, one compare per clock (bubble-sort schedule).
- Sits between a producer and a consumer, both on valid/ready. Accepts one packed 4-element vector, sorts it in place, then presents the sorted vector plus a swap count.
- Provides the time-multiplexed compare engine for the lab's sorting/ranking datapaths.

Parameters:
- DESCENDING, 0, 0 = ascending order (element 0 smallest); 1 = descending order.
- EARLY_EXIT, 1, 1 = finish after the first pass that makes no swap; 0 = always run all 6 compare steps.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a vector
- in_ready  output  1  block is idle and can accept a vector
- in_data  input  16  element k = in_data[4k+3:4k], k = 0..3
- out_valid  output  1  sorted vector available
- out_ready  input  1  consumer accepts the vector
- out_data  output  16  sorted vector, same packing as in_data
- swap_count  output  3  number of swaps performed, 0..6
- busy  output  1  high in CMP state

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state = IDLE; element registers r0..r3 = 0; swap_count = 0; out_valid = 0; busy = 0. in_ready = 1, because it decodes state == IDLE.
- Reset mid-operation: the current vector is discarded with no output. After rst_n rises the block is in IDLE and accepts on the next edge.
- States:
  - IDLE: in_ready = 1. Transaction when in_valid & in_ready at an edge: load r0..r3 from in_data, set pass = 0, idx = 0, swap_count = 0, pass_swapped = 0, go to CMP.
  - CMP: each cycle compare r[idx] (a) with r[idx+1] (b) through the comparator.
    - Swap condition: greater when DESCENDING = 0; less when DESCENDING = 1. Equal never swaps (stable sort).
    - On swap: exchange the two registers, increment swap_count, set pass_swapped.
    - Pass end is idx == 2 - pass. At pass end, if pass == 2, or (EARLY_EXIT and no swap in this pass including the current step), go to DONE. Otherwise pass++, idx = 0, pass_swapped = 0.
    - Otherwise idx++.
  - DONE: out_valid = 1. out_data and swap_count are held stable until out_ready is sampled high. On out_valid & out_ready, go to IDLE the same edge.
- Schedule: pass 0 compares (0,1), (1,2), (2,3); pass 1 compares (0,1), (1,2); pass 2 compares (0,1). Total 6 steps.
- Latency, counted from the accept edge E:
  - EARLY_EXIT = 0: out_valid rises after edge E+6.
  - Already-sorted input with EARLY_EXIT = 1: after E+3.
  - General EARLY_EXIT = 1 case: 3, 5 or 6 cycles.
- Back-to-back: in_ready is low from the accept edge until the output handshake completes. There is no overlap, so a new vector is accepted no earlier than the cycle after the out handshake.
- in_data and in_valid are ignored outside IDLE. out_ready is ignored outside DONE.
- Width rules: pass is 2 bits, idx is 2 bits, swap_count is 3 bits and saturates naturally at 6.

Decomposition:
- Shared package:
  - state encoding: IDLE = 2'd0, CMP = 2'd1, DONE = 2'd2
  - constants: NUM_ELEM = 4, ELEM_W = 4, LAST_PASS = 2
- Sub-module: one instance of the team's 4-bit comparator (fourbit_comparator), fed by an operand mux selecting r[idx] and r[idx+1]. No second comparator instance.
- The controller FSM and register file stay in sort4_ctrl.

Test Plan:
- Reset then ascending, EARLY_EXIT = 1: in_data elements {9,3,7,1} (k = 0..3) -> out_data elements {1,3,7,9}, swap_count = 5, out_valid after 6 CMP cycles.
- Already sorted {1,2,3,4}: EARLY_EXIT = 1 -> valid after 3 cycles, swap_count = 0. With EARLY_EXIT = 0 -> valid after 6 cycles, same data.
- DESCENDING = 1, {0,15,8,8} -> {15,8,8,0}. Equal 8s never swap; swap_count = 3.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_data and swap_count stable, in_ready = 0, a new in_valid is ignored. Raising out_ready completes the handshake, then the next vector is accepted.
- Worst case reverse {15,10,5,0} ascending -> {0,5,10,15}, swap_count = 6, 6 cycles regardless of EARLY_EXIT.
- Assert rst_n low during the 2nd CMP cycle -> immediate IDLE, out_valid = 0, swap_count = 0. After release, a fresh vector {4,4,4,4} sorts with swap_count = 0.
